wishbone_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one Wishbone slave port between NUM_MASTERS master_wishbone instances. Grant is held for a master's whole cycle (classic or burst) until it drops cyc. Routes the granted master's request signals to the slave and returns ack/err only to that master. Sits between the master_wishbone array and the single slave.

---
 rtl/wishbone_rr_arbiter_pkg.sv | 18 +
 rtl/wishbone_rr_arbiter_if.sv | 45 ++++
 rtl/wishbone_rr_arbiter_picker.sv | 29 ++
 rtl/wishbone_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Width of the optional stall watchdog counter.
  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/wishbone_rr_arbiter_if.sv
// Bundles the master-array side and the shared slave side of the arbiter.
// Handshake: a beat is offered while cyc & stb are high and completes on the cycle ack or err is high.
interface wishbone_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8
);
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [NUM_MASTERS*3-1:0]          m_cti_i;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [DATA_WIDTH-1:0]             m_data_o;
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_addr_o;
  logic [DATA_WIDTH-1:0]             s_data_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [2:0]                        s_cti_o;
  logic [DATA_WIDTH-1:0]             s_data_i;
  logic                              s_ack_i;
  logic                              s_err_i;

  // The arbiter's own view.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i, m_cti_i,
    input  s_data_i, s_ack_i, s_err_i,
    output m_ack_o, m_err_o, m_data_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o, s_cti_o
  );

  // The surrounding masters and slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i, m_cti_i,
    output s_data_i, s_ack_i, s_err_i,
    input  m_ack_o, m_err_o, m_data_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o, s_cti_o
  );
endinterface

// File: rtl/wishbone_rr_arbiter_picker.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo N.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          valid_o
);
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  wishbone_rr_arbiter_if.slave     bus,
  output logic [NUM_MASTERS-1:0]   grant_o,
  output logic                     busy_o,
  output arb_state_t               state_o
);
  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES >= (1 << TMO_CNT_W)) begin : g_bad_cfg
    $error("wishbone_rr_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
  end

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_next;
  logic [NUM_MASTERS-1:0] req_eff, pick;
  logic                   pick_valid;
  logic                   timeout_hit;

  logic                   g_cyc, g_stb, g_we;
  logic [ADDR_WIDTH-1:0]  g_addr;
  logic [DATA_WIDTH-1:0]  g_data;
  logic [SEL_WIDTH-1:0]   g_sel;
  logic [2:0]             g_cti;
  logic [PTR_W-1:0]       g_idx;

  rr_priority_picker #(.N(NUM_MASTERS), .PW(PTR_W)) u_picker (
    .req_i   (req_eff),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  // Select the granted master's request slices; all zero when nobody holds a grant.
  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_data = '0;
    g_sel  = '0;
    g_cti  = '0;
    g_idx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_cyc  = bus.m_cyc_i[i];
        g_stb  = bus.m_stb_i[i];
        g_we   = bus.m_we_i[i];
        g_addr = bus.m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_data = bus.m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        g_sel  = bus.m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        g_cti  = bus.m_cti_i[i*3 +: 3];
        g_idx  = PTR_W'(i);
      end
    end
  end

  assign ptr_next = (g_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : g_idx + PTR_W'(1);

`ifdef WB_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [NUM_MASTERS-1:0] blocked_q, blocked_d;
  logic                   stall;

  always_comb begin
    stall       = (state_q == OWNED) && g_stb && !bus.s_ack_i && !bus.s_err_i;
    timeout_hit = stall && (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d   = tmo_cnt_q;
    if (state_q != OWNED || timeout_hit || bus.s_ack_i || bus.s_err_i) tmo_cnt_d = '0;
    else if (stall) tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
    // A timed-out master stays locked out until it drops cyc.
    blocked_d   = (blocked_q & bus.m_cyc_i) | (timeout_hit ? grant_q : '0);
    req_eff     = bus.m_cyc_i & ~blocked_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      blocked_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      blocked_q <= blocked_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req_eff     = bus.m_cyc_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          grant_d = pick;
        end
      end
      OWNED: begin
        if (!g_cyc || timeout_hit) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    busy_o       = (state_q == OWNED);
    grant_o      = grant_q;
    state_o      = state_q;
    bus.s_cyc_o  = busy_o & g_cyc;
    bus.s_stb_o  = busy_o & g_stb;
    bus.s_we_o   = busy_o & g_we;
    bus.s_addr_o = busy_o ? g_addr : '0;
    bus.s_data_o = busy_o ? g_data : '0;
    bus.s_sel_o  = busy_o ? g_sel  : '0;
    bus.s_cti_o  = busy_o ? g_cti  : '0;
    bus.m_ack_o  = {NUM_MASTERS{bus.s_ack_i & busy_o}} & grant_q;
    bus.m_err_o  = {NUM_MASTERS{(bus.s_err_i | timeout_hit) & busy_o}} & grant_q;
    bus.m_data_o = bus.s_data_i;
  end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: grant order, muxing, return path, bursts and reset.
module tb_wishbone_rr_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NM-1:0] grant_o;
  logic          busy_o;
  arb_state_t    state_o;

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q[$];
  logic [39:0] sb_e;

  wishbone_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  wishbone_rr_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .state_o (state_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_master(input int i, input logic cyc, input logic stb, input logic we,
                              input logic [31:0] addr, input logic [31:0] data, input logic [2:0] cti);
    bus.m_cyc_i[i]           = cyc;
    bus.m_stb_i[i]           = stb;
    bus.m_we_i[i]            = we;
    bus.m_addr_i[i*AW +: AW] = addr;
    bus.m_data_i[i*DW +: DW] = data;
    bus.m_sel_i[i*SW +: SW]  = {SW{cyc}};
    bus.m_cti_i[i*3 +: 3]    = cti;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < NM; i++) drive_master(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
  endtask

  task automatic do_reset();
    clear_masters();
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_grant(input logic [NM-1:0] exp, input string tag);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (grant_o != '0) break;
    end
    chk({tag, " grant"}, 64'(grant_o), 64'(exp));
  endtask

  // Entered at the negedge of the owner's first OWNED cycle; leaves at the RELEASE negedge.
  task automatic do_owner(input int i, input logic [31:0] rdata, input string tag);
    logic [NM-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    tick();
    bus.s_ack_i  = 1'b1;
    bus.s_data_i = rdata;
    exp_q.push_back({4'h0, oh, rdata});
    tick();
    bus.s_ack_i = 1'b0;
    drive_master(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(negedge clk_i);
    chk({tag, " s_cyc follows dropped cyc"}, 64'(bus.s_cyc_o), 64'(0));
    @(negedge clk_i);
    chk({tag, " release state"}, 64'(state_o), 64'(RELEASE));
    chk({tag, " release grant"}, 64'(grant_o), 64'(0));
    chk({tag, " release s_cyc"}, 64'(bus.s_cyc_o), 64'(0));
  endtask

  // Scoreboard: every ack seen must match the next expected {ack vector, read data}.
  always @(negedge clk_i) begin
    if (!rst_i && bus.m_ack_o != '0) begin
      if (exp_q.size() == 0) begin
        chk("sb unexpected ack", 64'(bus.m_ack_o), 64'(0));
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb ack vector", 64'(bus.m_ack_o), 64'(sb_e[35:32]));
        chk("sb read data", 64'(bus.m_data_o), 64'(sb_e[31:0]));
      end
    end
  end

  initial begin
    rst_i        = 1'b1;
    bus.s_ack_i  = 1'b0;
    bus.s_err_i  = 1'b0;
    bus.s_data_i = '0;
    clear_masters();
    repeat (3) tick();
    @(negedge clk_i);
    chk("reset grant", 64'(grant_o), 64'(0));
    chk("reset busy", 64'(busy_o), 64'(0));
    chk("reset s_cyc", 64'(bus.s_cyc_o), 64'(0));
    chk("reset s_addr", 64'(bus.s_addr_o), 64'(0));
    chk("reset m_ack", 64'(bus.m_ack_o), 64'(0));
    chk("reset state", 64'(state_o), 64'(IDLE));
    tick();
    rst_i = 1'b0;

    // Stray slave termination while idle is dropped.
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b1;
    @(negedge clk_i);
    chk("idle ack dropped", 64'(bus.m_ack_o), 64'(0));
    chk("idle err dropped", 64'(bus.m_err_o), 64'(0));
    tick();
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;

    // Single write from master 2.
    drive_master(2, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, CTI_CLASSIC);
    @(negedge clk_i);
    chk("t1 grant latency", 64'(grant_o), 64'(0));
    @(negedge clk_i);
    chk("t1 grant", 64'(grant_o), 64'(4'b0100));
    chk("t1 busy", 64'(busy_o), 64'(1));
    chk("t1 s_cyc", 64'(bus.s_cyc_o), 64'(1));
    chk("t1 s_stb", 64'(bus.s_stb_o), 64'(1));
    chk("t1 s_we", 64'(bus.s_we_o), 64'(1));
    chk("t1 s_addr", 64'(bus.s_addr_o), 64'h1000);
    chk("t1 s_data", 64'(bus.s_data_o), 64'hDEAD_BEEF);
    chk("t1 s_sel", 64'(bus.s_sel_o), 64'hF);
    tick();
    bus.s_err_i = 1'b1;
    @(negedge clk_i);
    chk("t1 err routed", 64'(bus.m_err_o), 64'(4'b0100));
    tick();
    bus.s_err_i = 1'b0;
    do_owner(2, 32'h0, "t1");

    // Contention after reset: 0, 1, 3 in order.
    do_reset();
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    drive_master(1, 1'b1, 1'b1, 1'b0, 32'h110, 32'h0, CTI_CLASSIC);
    drive_master(3, 1'b1, 1'b1, 1'b0, 32'h130, 32'h0, CTI_CLASSIC);
    wait_grant(4'b0001, "t2 m0");
    chk("t2 m0 addr", 64'(bus.s_addr_o), 64'h100);
    do_owner(0, 32'hA0A0_0000, "t2 m0");
    wait_grant(4'b0010, "t2 m1");
    chk("t2 m1 addr", 64'(bus.s_addr_o), 64'h110);
    do_owner(1, 32'hA1A1_1111, "t2 m1");
    wait_grant(4'b1000, "t2 m3");
    chk("t2 m3 addr", 64'(bus.s_addr_o), 64'h130);
    do_owner(3, 32'hA3A3_3333, "t2 m3");

    // Fairness: master 1 re-requests but master 2 gets the bus first.
    tick();
    drive_master(1, 1'b1, 1'b1, 1'b1, 32'h210, 32'h1, CTI_CLASSIC);
    wait_grant(4'b0010, "t3 m1 first");
    tick();
    drive_master(2, 1'b1, 1'b1, 1'b1, 32'h220, 32'h2, CTI_CLASSIC);
    tick();
    @(negedge clk_i);
    chk("t3 mid-cycle request ignored", 64'(grant_o), 64'(4'b0010));
    do_owner(1, 32'h0000_0B01, "t3 m1");
    tick();
    drive_master(1, 1'b1, 1'b1, 1'b1, 32'h210, 32'h1, CTI_CLASSIC);
    wait_grant(4'b0100, "t3 m2 before m1");
    chk("t3 m2 addr", 64'(bus.s_addr_o), 64'h220);
    do_owner(2, 32'h0000_0B02, "t3 m2");
    wait_grant(4'b0010, "t3 m1 again");
    do_owner(1, 32'h0000_0B03, "t3 m1b");

    // Burst read by master 0 with master 3 waiting, including one stb gap.
    tick();
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, CTI_INC);
    wait_grant(4'b0001, "t4 m0");
    tick();
    drive_master(3, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h3333_3333, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        bus.m_stb_i[0] = 1'b0;
        @(negedge clk_i);
        chk("t4 gap s_stb", 64'(bus.s_stb_o), 64'(0));
        chk("t4 gap grant", 64'(grant_o), 64'(4'b0001));
        tick();
      end
      drive_master(0, 1'b1, 1'b1, 1'b0, 32'h2000 + 32'(4*b), 32'h0, (b == 3) ? CTI_END : CTI_INC);
      bus.s_ack_i  = 1'b1;
      bus.s_data_i = 32'h11 * 32'(b + 1);
      exp_q.push_back({8'b0000_0001, 32'h11 * 32'(b + 1)});
      @(negedge clk_i);
      chk("t4 beat addr", 64'(bus.s_addr_o), 64'h2000 + 64'(4*b));
      chk("t4 beat cti", 64'(bus.s_cti_o), (b == 3) ? 64'(CTI_END) : 64'(CTI_INC));
      chk("t4 beat grant", 64'(grant_o), 64'(4'b0001));
      tick();
      bus.s_ack_i = 1'b0;
    end
    drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(negedge clk_i);
    chk("t4 end s_cyc", 64'(bus.s_cyc_o), 64'(0));
    wait_grant(4'b1000, "t4 m3 after burst");
    chk("t4 m3 addr", 64'(bus.s_addr_o), 64'h3000);
    do_owner(3, 32'h5A5A_5A5A, "t4 m3");

    // Reset during beat 2 of a burst.
    tick();
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, CTI_INC);
    wait_grant(4'b0001, "t5 m0");
    tick();
    bus.s_ack_i  = 1'b1;
    bus.s_data_i = 32'h11;
    exp_q.push_back({8'b0000_0001, 32'h11});
    @(negedge clk_i);
    tick();
    bus.s_ack_i  = 1'b0;
    bus.s_data_i = 32'hCAFE_F00D;
    drive_master(0, 1'b1, 1'b1, 1'b0, 32'h2004, 32'h0, CTI_INC);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5 read data broadcast", 64'(bus.m_data_o), 64'hCAFE_F00D);
    @(negedge clk_i);
    chk("t5 reset grant", 64'(grant_o), 64'(0));
    chk("t5 reset s_cyc", 64'(bus.s_cyc_o), 64'(0));
    chk("t5 reset busy", 64'(busy_o), 64'(0));
    chk("t5 reset state", 64'(state_o), 64'(IDLE));
    tick();
    rst_i = 1'b0;
    clear_masters();
    repeat (3) tick();
    chk("sb queue drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
